// File: rtl/instr_mem_pkg.sv
// Shared constants, defaults and types for the instruction-memory fetch unit.
package instr_mem_pkg;

   localparam int unsigned DEF_ADDR_W    = 64;
   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_DEPTH     = 64;
   localparam logic [63:0] DEF_BASE_ADDR = 64'h0;

   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;

   // Returned in place of memory data whenever a fetch faults.
   localparam logic [31:0] NOP_INSTR = 32'hD503201F;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W instruction storage: one synchronous write port, one registered read port.
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned IDX_W  = idx_width(DEF_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // NOTE: the storage array has no reset branch; program contents survive rst_n
   // and a reset would also prevent mapping onto RAM macros.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_idx];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem_fetch.sv
// Fetch front-end: address decode, program-load path and a one-deep response register.
module instr_mem_fetch
   import instr_mem_pkg::*;
#(
   parameter int unsigned        ADDR_W    = DEF_ADDR_W,
   parameter int unsigned        DATA_W    = DEF_DATA_W,
   parameter int unsigned        DEPTH     = DEF_DEPTH,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_err,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [1:0]        rsp_fault
);

   localparam int unsigned IDX_W = idx_width(DEPTH);

   // Misalignment wins over range; the subtraction wraps for addresses below
   // BASE_ADDR, so those are caught by the explicit lower-bound compare.
   function automatic logic [1:0] f_classify(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] word;
      word = (a - BASE_ADDR) >> 2;
      if (a[1:0] != 2'b00) begin
         return FAULT_MISALIGN;
      end
      if ((a < BASE_ADDR) || (word >= ADDR_W'(DEPTH))) begin
         return FAULT_RANGE;
      end
      return FAULT_OK;
   endfunction

   function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   rsp_state_e        r_state;
   rsp_state_e        w_state_nxt;
   logic [1:0]        r_fault;
   logic              r_load_err;
   logic [1:0]        w_req_fault;
   logic [1:0]        w_load_fault;
   logic              w_accept;
   logic              w_handshake;
   logic              w_rd_en;
   logic              w_wr_en;
   logic [DATA_W-1:0] w_rd_data;

   assign w_req_fault  = f_classify(req_addr);
   assign w_load_fault = f_classify(load_addr);

   assign rsp_valid   = (r_state == ST_FULL);
   assign req_ready   = !load_en && (!rsp_valid || rsp_ready);
   assign w_accept    = req_valid && req_ready;
   assign w_handshake = rsp_valid && rsp_ready;
   assign w_rd_en     = w_accept && (w_req_fault == FAULT_OK);
   assign w_wr_en     = load_en && (w_load_fault == FAULT_OK);

   instr_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (f_index(load_addr)),
      .i_wr_data (load_data),
      .i_rd_en   (w_rd_en),
      .i_rd_idx  (f_index(req_addr)),
      .o_rd_data (w_rd_data)
   );

   // NOTE: the default assignment up front keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_handshake && !w_accept) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_fault    <= FAULT_OK;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_load_err <= load_en && (w_load_fault != FAULT_OK);
         if (w_accept) begin
            r_fault <= w_req_fault;
         end
      end
   end

   // The read register holds its last value on faulted fetches; the fault code selects NOP.
   assign rsp_instr = (r_fault == FAULT_OK) ? w_rd_data : DATA_W'(NOP_INSTR);
   assign rsp_fault = r_fault;
   assign load_err  = r_load_err;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: load, fetch, stream, stall, faults and reset.
module tb_instr_mem_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [63:0] load_addr;
   logic [31:0] load_data;
   logic        load_err;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [1:0]  rsp_fault;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'hD503201F;

   always #5 clk = ~clk;

   instr_mem_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .load_err  (load_err),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_fault (rsp_fault)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_rsp(input string tag, input logic [31:0] instr, input logic [1:0] fault);
      check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_instr"}, 64'(rsp_instr), 64'(instr));
      check({tag, "_fault"}, 64'(rsp_fault), 64'(fault));
   endtask

   task automatic do_load(input logic [63:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
   endtask

   task automatic do_req(input logic [63:0] a);
      req_valid = 1'b1;
      req_addr  = a;
   endtask

   initial begin
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

      // Reset state
      #3;
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_instr", 64'(rsp_instr), 64'd0);
      check("rst_fault", 64'(rsp_fault), 64'd0);
      check("rst_load_err", 64'(load_err), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Program load; a concurrent request must be refused
      @(negedge clk); do_load(64'h38, 32'h8B1F03E9); do_req(64'h38); #1;
      check("load_blocks_req", 64'(req_ready), 64'd0);
      @(negedge clk); do_load(64'h3C, 32'hB2048D29); req_valid = 1'b0;
      check("load_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk); do_load(64'h40, 32'hD37F3129);
      check("load_ok_no_err", 64'(load_err), 64'd0);
      @(negedge clk); load_en = 1'b0; do_req(64'h3C); #1;
      check("req_ready_idle", 64'(req_ready), 64'd1);
      @(negedge clk); req_valid = 1'b0;
      check_rsp("fetch_3c", 32'hB2048D29, 2'b00);
      @(negedge clk);
      check("rsp_cleared", 64'(rsp_valid), 64'd0);

      // Back-to-back stream
      do_req(64'h38);
      @(negedge clk); check_rsp("stream0", 32'h8B1F03E9, 2'b00); do_req(64'h3C);
      @(negedge clk); check_rsp("stream1", 32'hB2048D29, 2'b00); do_req(64'h40);
      @(negedge clk); check_rsp("stream2", 32'hD37F3129, 2'b00); req_valid = 1'b0;
      @(negedge clk); check("stream_end", 64'(rsp_valid), 64'd0);

      // Stall for three cycles, then release
      rsp_ready = 1'b0; do_req(64'h40);
      @(negedge clk); check_rsp("stall_first", 32'hD37F3129, 2'b00); do_req(64'h38); #1;
      check("stall_req_ready", 64'(req_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_rsp("stall_hold", 32'hD37F3129, 2'b00);
         check("stall_hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1; req_valid = 1'b0;
      @(negedge clk); check("stall_delivered_once", 64'(rsp_valid), 64'd0);

      // Fault classification and precedence
      do_req(64'h3E);
      @(negedge clk); check_rsp("misalign", NOP, 2'b01); do_req(64'h100);
      @(negedge clk); check_rsp("range", NOP, 2'b10); do_req(64'h102);
      @(negedge clk); check_rsp("misalign_over_range", NOP, 2'b01); do_req(64'hFFFF_FFFF_FFFF_FFFC);
      @(negedge clk); check_rsp("range_high", NOP, 2'b10); req_valid = 1'b0;

      // Rejected loads pulse load_err and leave memory untouched
      do_load(64'h3E, 32'hFFFF_FFFF);
      @(negedge clk); load_en = 1'b0;
      check("load_err_misalign", 64'(load_err), 64'd1);
      do_req(64'h3C);
      @(negedge clk); req_valid = 1'b0;
      check("load_err_one_cycle", 64'(load_err), 64'd0);
      check_rsp("mem_unchanged_3c", 32'hB2048D29, 2'b00);
      do_load(64'h0, 32'hA5A5_A5A5);
      @(negedge clk); do_load(64'h100, 32'h0000_0000);
      @(negedge clk); load_en = 1'b0; do_req(64'h0);
      check("load_err_range", 64'(load_err), 64'd1);
      @(negedge clk); req_valid = 1'b0;
      check_rsp("mem_unchanged_0", 32'hA5A5_A5A5, 2'b00);

      // Load priority and read-after-write on the following cycle
      @(negedge clk); do_load(64'h38, 32'h1234_5678); do_req(64'h38); #1;
      check("load_priority", 64'(req_ready), 64'd0);
      @(negedge clk); load_en = 1'b0; #1;
      check("raw_not_accepted", 64'(rsp_valid), 64'd0);
      check("raw_ready", 64'(req_ready), 64'd1);
      @(negedge clk); req_valid = 1'b0;
      check_rsp("raw_new_data", 32'h1234_5678, 2'b00);

      // Reset while stalled discards the response; memory survives
      @(negedge clk); rsp_ready = 1'b0; do_req(64'h3C);
      @(negedge clk); req_valid = 1'b0;
      check_rsp("pre_reset_full", 32'hB2048D29, 2'b00);
      #2 rst_n = 1'b0; #1;
      check("async_rst_valid", 64'(rsp_valid), 64'd0);
      check("async_rst_instr", 64'(rsp_instr), 64'd0);
      @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      check("no_reissue", 64'(rsp_valid), 64'd0);
      do_req(64'h40);
      @(negedge clk); req_valid = 1'b0;
      check_rsp("retained_40", 32'hD37F3129, 2'b00);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_fetch.md
INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 64, number of instruction words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port load_en  input  1  program-load write strobe.
REQ-008 SHALL have port load_addr  input  ADDR_W  byte address of load word.
REQ-009 SHALL have port load_data  input  DATA_W  instruction word to store.
REQ-010 SHALL have port load_err  output  1  one-cycle pulse: rejected load.
REQ-011 SHALL have port req_valid  input  1  fetch request valid.
REQ-012 SHALL have port req_ready  output  1  fetch request accepted this cycle.
REQ-013 SHALL have port req_addr  input  ADDR_W  fetch byte address (PC).
REQ-014 SHALL have port rsp_valid  output  1  response valid.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port rsp_instr  output  DATA_W  fetched instruction.
REQ-017 SHALL have port rsp_fault  output  2  00 ok, 01 misaligned, 10 out-of-range.

Function
REQ-018 Word index SHALL be (addr - BASE_ADDR) >> 2; address in range iff addr >= BASE_ADDR and index < DEPTH.
REQ-019 Request SHALL be accepted when req_valid && req_ready.
REQ-020 req_ready SHALL equal !load_en && (!rsp_valid || rsp_ready), combinationally.
REQ-021 Accepted request SHALL produce rsp_valid=1 with rsp_instr/rsp_fault on the next clock edge: latency exactly 1 cycle.
REQ-022 Back-to-back accepted requests with rsp_ready=1 SHALL sustain one response per cycle.
REQ-023 While rsp_valid && !rsp_ready, rsp_valid, rsp_instr and rsp_fault SHALL hold stable.
REQ-024 rsp_valid SHALL clear after a handshake (rsp_valid && rsp_ready) with no new request accepted in that cycle.
REQ-025 Output register FSM: EMPTY (rsp_valid=0) -> FULL on accept; FULL -> FULL on handshake plus accept, or on stall; FULL -> EMPTY on handshake without accept.
REQ-026 Fault precedence: addr[1:0] != 0 yields 01 even when also out of range; otherwise out of range yields 10.
REQ-027 Faulted response SHALL return rsp_instr = NOP constant 32'hD503201F; memory SHALL NOT be read.
REQ-028 Load with load_en=1, aligned and in range, SHALL write load_data to the word at the clock edge.
REQ-029 Misaligned or out-of-range load SHALL leave memory unchanged and pulse load_err for the following cycle.
REQ-030 load_en SHALL take priority: no request is accepted in any cycle with load_en=1, so read-during-write never occurs.
REQ-031 A fetch accepted in the cycle after a load to the same word SHALL return the newly loaded data.
REQ-032 Index computation SHALL use ADDR_W-bit unsigned arithmetic; addresses wrapping below BASE_ADDR SHALL be classed out-of-range.

Reset
REQ-033 On rst_n low, asynchronously: rsp_valid=0, rsp_instr=0, rsp_fault=00, load_err=0, FSM=EMPTY.
REQ-034 A response in flight or stalled at reset assertion SHALL be discarded, never re-issued.
REQ-035 Memory contents SHALL NOT be reset; contents are retained across reset and undefined after power-up.

Structure
REQ-036 Package instr_mem_pkg SHALL hold fault-code constants (FAULT_OK, FAULT_MISALIGN, FAULT_RANGE), the NOP constant and default parameter values.
REQ-037 Storage SHALL be sub-module instr_mem_array (DEPTH x DATA_W, one synchronous write port, one synchronous read port); instr_mem_fetch holds decode, FSM and handshake logic.

Verification
REQ-038 Load the words 8B1F03E9, B2048D29 and D37F3129 at 0x38, 0x3C and 0x40; fetch 0x3C -> next cycle rsp_valid=1, rsp_instr=B2048D29, rsp_fault=00.
REQ-039 Stream fetches 0x38, 0x3C, 0x40 with rsp_ready=1 -> three consecutive responses 8B1F03E9, B2048D29, D37F3129.
REQ-040 Hold rsp_ready=0 for 3 cycles with the response FULL -> req_ready=0 and response stable; release -> data delivered once.
REQ-041 Fetch 0x3E -> rsp_fault=01, rsp_instr=D503201F; fetch BASE_ADDR+4*DEPTH -> rsp_fault=10; load to 0x3E -> load_err pulse, memory unchanged.
REQ-042 Assert load_en (0x38, 12345678) with req_valid=1 -> req_ready=0; next-cycle fetch of 0x38 returns 12345678.
REQ-043 Assert rst_n=0 while stalled FULL -> rsp_valid=0 immediately; after release, fetch 0x40 still returns D37F3129.
